// File: rtl/mcycle_unit.sv
// Iterative radix-2 multiply/divide engine for the Execute stage.
// Produces Busy/Done/MCycleWA3 for the hazard unit; one step per cycle, latency WIDTH+1.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    input  logic [3:0]       WA3,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       MCycleWA3
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W    = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_COMPUTE = 2'b01,
        S_DONE    = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_2W) : v;
    endfunction

    state_t               r_state;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_addend;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_result1;
    logic [WIDTH-1:0]     r_result2;
    logic                 r_busy;
    logic                 r_done;
    logic [3:0]           r_wa3;

    logic                 w_signed;
    logic                 w_s1;
    logic                 w_s2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_div0;
    logic [WIDTH-1:0]     w_acc_hi;
    logic [WIDTH-1:0]     w_acc_lo;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH+1:0]     w_div_diff;
    logic                 w_div_fits;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res1;
    logic [WIDTH-1:0]     w_res2;
    logic                 w_unused;

    // Operand magnitudes and sign bookkeeping taken at the accepting edge.
    assign w_signed = ~MCycleOp[0];
    assign w_s1     = w_signed & Operand1[WIDTH-1];
    assign w_s2     = w_signed & Operand2[WIDTH-1];
    assign w_mag1   = f_cneg(Operand1, w_s1);
    assign w_mag2   = f_cneg(Operand2, w_s2);
    assign w_div0   = (Operand2 == ZERO_W);

    // Accumulator halves: mul {partial product, multiplier}; div {remainder, quotient}.
    assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_acc_lo = r_acc[WIDTH-1:0];

    assign w_mul_sum  = {1'b0, w_acc_hi} + (w_acc_lo[0] ? {1'b0, r_addend} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, w_acc_lo[WIDTH-1:1]};

    // Restoring step: a borrow out of the subtractor means the divisor did not fit.
    assign w_div_shift = {w_acc_hi, w_acc_lo[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_addend};
    assign w_div_fits  = ~w_div_diff[WIDTH+1];
    assign w_div_next  = w_div_fits ? {w_div_diff[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b1}
                                    : {w_div_shift[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b0};
    assign w_acc_next  = r_is_div ? w_div_next : w_mul_next;
    assign w_unused    = w_div_diff[WIDTH];

    // Sign fix-up applied to the result of the final step.
    assign w_prod = f_cneg2(w_acc_next, r_neg_q);
    assign w_quo  = f_cneg(w_acc_next[WIDTH-1:0], r_neg_q);
    assign w_rem  = f_cneg(w_acc_next[2*WIDTH-1:WIDTH], r_neg_r);
    assign w_res1 = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    assign w_res2 = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];

    // Control FSM with the iteration datapath and registered handshake outputs.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= S_IDLE;
            r_count   <= {CW{1'b0}};
            r_acc     <= {(2*WIDTH){1'b0}};
            r_addend  <= ZERO_W;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result1 <= ZERO_W;
            r_result2 <= ZERO_W;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wa3     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_state  <= S_COMPUTE;
                        r_busy   <= 1'b1;
                        r_count  <= {CW{1'b0}};
                        r_wa3    <= WA3;
                        r_is_div <= MCycleOp[1];
                        r_acc    <= {ZERO_W, (MCycleOp[1] ? w_mag1 : w_mag2)};
                        r_addend <= MCycleOp[1] ? w_mag2 : w_mag1;
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        r_neg_q  <= (w_s1 ^ w_s2) & ~(MCycleOp[1] & w_div0);
                        r_neg_r  <= w_s1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc_next;
                    if (r_count == LAST_STEP) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_result1 <= w_res1;
                        r_result2 <= w_res2;
                    end else begin
                        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Result1   = r_result1;
    assign Result2   = r_result2;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign MCycleWA3 = r_wa3;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_mcycle_unit;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          Start = 1'b0;
    logic [1:0]    MCycleOp = 2'b00;
    logic [W-1:0]  Operand1 = '0;
    logic [W-1:0]  Operand2 = '0;
    logic [3:0]    WA3 = 4'd0;
    logic [W-1:0]  Result1;
    logic [W-1:0]  Result2;
    logic          Busy;
    logic          Done;
    logic [3:0]    MCycleWA3;

    int n_checks = 0;
    int n_errors = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2), .WA3(WA3),
        .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
        .MCycleWA3(MCycleWA3)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic plus the two architectural special cases.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r1, output logic [W-1:0] r2);
        longint     sp;
        logic [63:0] p;
        int         sa;
        int         sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                p  = sp;
                r1 = p[31:0];
                r2 = p[63:32];
            end
            2'b01: begin
                p  = {32'd0, a} * {32'd0, b};
                r1 = p[31:0];
                r2 = p[63:32];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    r1 = 32'hFFFF_FFFF; r2 = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r1 = 32'h8000_0000; r2 = 32'd0;
                end else begin
                    r1 = 32'(sa / sb); r2 = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r1 = 32'hFFFF_FFFF; r2 = a;
                end else begin
                    r1 = a / b; r2 = a % b;
                end
            end
        endcase
    endtask

    // Drive a request before a rising edge, then scramble inputs after it is accepted.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] wa);
        MCycleOp = op; Operand1 = a; Operand2 = b; WA3 = wa; Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Operand1 = $urandom; Operand2 = $urandom;
        MCycleOp = 2'($urandom_range(0, 3)); WA3 = 4'($urandom_range(0, 15));
    endtask

    // Follow cycles 1..W+1 after acceptance; optionally pulse a stray Start mid-flight.
    task automatic wait_done(input logic [W-1:0] e1, input logic [W-1:0] e2, input logic [3:0] ewa,
                             input int inject, input string tag);
        logic busy_ok;
        busy_ok = 1'b1;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge CLK);
            if (k <= W && !(Busy === 1'b1 && Done === 1'b0 && MCycleWA3 === ewa)) busy_ok = 1'b0;
            if (inject != 0 && k == inject) begin
                Start = 1'b1; WA3 = 4'd9;
                Operand1 = $urandom; Operand2 = $urandom;
            end
            if (inject != 0 && k == inject + 1) Start = 1'b0;
        end
        check({tag, " busy_window"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_done"}, 64'({Busy, Done}), 64'(2'b01));
        check({tag, " result1"}, 64'(Result1), 64'(e1));
        check({tag, " result2"}, 64'(Result2), 64'(e2));
        check({tag, " wa3"}, 64'(MCycleWA3), 64'(ewa));
    endtask

    task automatic idle_check(input string tag);
        @(negedge CLK);
        check({tag, " idle"}, 64'({Busy, Done}), 64'(2'b00));
    endtask

    vec_t        vecs[12];
    logic [W-1:0] m1;
    logic [W-1:0] m2;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [1:0]   rop;
    logic [3:0]   rwa;
    logic [W-1:0] corners[6];

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF};
        vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[4]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
        vecs[5]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[7]  = '{2'b10, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{2'b11, 32'h0000_0007, 32'h0000_000A, 32'h0000_0000, 32'h0000_0007};
        vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{2'b10, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        corners  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};

        repeat (2) @(negedge CLK);
        check("reset_state", 64'({Result1, Result2, Busy, Done, MCycleWA3}) | 64'({Result1, Result2}), 64'd0);
        RESETn = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
            wait_done(vecs[i].r1, vecs[i].r2, 4'(i), 0, $sformatf("vec%0d", i));
            idle_check($sformatf("vec%0d", i));
        end

        start_op(2'b01, 32'd6, 32'd7, 4'd5);
        wait_done(32'd42, 32'd0, 4'd5, 10, "ignored_start");
        idle_check("ignored_start");

        model(2'b01, 32'd3, 32'd5, m1, m2);
        start_op(2'b01, 32'd3, 32'd5, 4'd2);
        wait_done(m1, m2, 4'd2, 0, "b2b_first");
        model(2'b00, 32'hFFFF_FFFE, 32'd9, m1, m2);
        start_op(2'b00, 32'hFFFF_FFFE, 32'd9, 4'd3);
        wait_done(m1, m2, 4'd3, 0, "b2b_second");
        idle_check("b2b_second");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
            rwa = 4'($urandom_range(0, 15));
            model(rop, ra, rb, m1, m2);
            start_op(rop, ra, rb, rwa);
            wait_done(m1, m2, rwa, 0, $sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i));
        end

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA);
        repeat (12) @(negedge CLK);
        #1;
        RESETn = 1'b0;
        #1;
        check("async_reset_outputs", 64'({Busy, Done, MCycleWA3}), 64'd0);
        check("async_reset_results", 64'({Result1, Result2}), 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (W + 4) @(negedge CLK);
        check("abandoned_no_done", 64'({Busy, Done, MCycleWA3}), 64'd0);
        start_op(2'b01, 32'd6, 32'd7, 4'd1);
        wait_done(32'd42, 32'd0, 4'd1, 0, "post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
